fixed_point_multiplier: RTL

- Sequential shift-and-add multiplier. It is the inverse companion of the bit-guess divider: it takes an unsigned Q10.10 quotient and a 3-bit integer divisor, and rebuilds the Q13.10 dividend.
- Uses the same in_valid / out_valid single-stream protocol as the divider, so the two can be chained back-to-back for self-checking round trips.
- Retires one multiplier bit per cycle and exits early once the remaining multiplier bits are zero.

---
 rtl/fixed_point_multiplier_pkg.sv | 18 +
 rtl/fixed_point_multiplier.sv | 85 ++++++++
 2 files changed

// File: rtl/fixed_point_multiplier_pkg.sv
// rtl/fixed_point_multiplier_pkg.sv - shared fixed-point constants and FSM encoding for the divider/multiplier pair
package fixed_point_multiplier_pkg;

  localparam int WIDTH_A_DEF = 20;
  localparam int WIDTH_B_DEF = 3;
  localparam int FRAC_DEF    = 10;

  // 1.0 in Q10.10
  localparam logic [WIDTH_A_DEF-1:0] ONE = WIDTH_A_DEF'(1) << FRAC_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    MULT = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/fixed_point_multiplier.sv
// rtl/fixed_point_multiplier.sv - sequential shift-and-add Q10.10 x integer multiplier with early exit
module fixed_point_multiplier
  import fixed_point_multiplier_pkg::*;
#(
  parameter int WIDTH_A = WIDTH_A_DEF,
  parameter int WIDTH_B = WIDTH_B_DEF,
  parameter int FRAC    = FRAC_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [WIDTH_A-1:0]         in_data_1,
  input  logic [WIDTH_B-1:0]         in_data_2,
  output logic                       out_valid,
  output logic [WIDTH_A+WIDTH_B-1:0] out_data
);

  localparam int PW = WIDTH_A + WIDTH_B;

  // FRAC only labels the binary point; the arithmetic is plain integer
  if (FRAC > WIDTH_A) begin : g_frac_check
    $error("FRAC larger than WIDTH_A");
  end

  state_t              state;
  logic [PW-2:0]       mcand;
  logic [WIDTH_B-1:0]  mplr;
  logic [PW-1:0]       acc;

  logic [PW-1:0]       partial;
  logic [PW-1:0]       acc_sum;
  logic [WIDTH_B-1:0]  mplr_shr;

  always_comb begin
    partial  = '0;
    if (mplr[0]) partial = {1'b0, mcand};
    acc_sum  = acc + partial;
    mplr_shr = mplr >> 1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      mcand     <= '0;
      mplr      <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand <= {{(WIDTH_B-1){1'b0}}, in_data_1};
            mplr  <= in_data_2;
            state <= LOAD;
          end
        end
        LOAD: begin
          // a held strobe keeps overwriting; the last sampled pair wins
          if (in_valid) begin
            mcand <= {{(WIDTH_B-1){1'b0}}, in_data_1};
            mplr  <= in_data_2;
          end else begin
            acc   <= '0;
            state <= MULT;
          end
        end
        MULT: begin
          acc   <= acc_sum;
          mcand <= mcand << 1;
          mplr  <= mplr_shr;
          if (mplr_shr == '0) state <= DONE;
        end
        DONE: begin
          out_valid <= 1'b1;
          out_data  <= acc;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
